// File: rtl/bs_arbiter_rr_bp.sv
// Packet router: pops one head at a time, decodes dst, unicasts or broadcasts; two-class RR + aging.
// Latency: pndng sampled at E0 -> pop E0..E1 -> push E2..E3 when targets are free (1 packet / 4 cycles).
// Backpressure: holds packet in ROUTE while any target is full; drops with err after bp_timeout cycles.
module bs_arbiter_rr_bp #(
    parameter int         drvrs      = 4,
    parameter int         pckg_sz    = 16,
    parameter logic [7:0] broadcast  = {8{1'b1}},
    parameter int         max_wait   = 8,
    parameter int         bp_timeout = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs-1:0]         prio,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     busy,
    output logic                     err,
    output logic [15:0]              drop_cnt
);
    localparam int IDXW  = $clog2(drvrs);
    localparam int AGEW  = $clog2(max_wait + 1);
    localparam int WAITW = $clog2(bp_timeout + 1);
    localparam logic [AGEW-1:0]  AGE_MAX  = AGEW'(max_wait);
    localparam logic [WAITW-1:0] WAIT_END = WAITW'(bp_timeout - 1);
    localparam logic [drvrs-1:0] ONE      = {{(drvrs-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GRANT, ROUTE, PUSH} state_t;

    state_t             state, state_nxt;
    logic [IDXW-1:0]    rr_ptr, src, src_nxt, win, rr_nxt;
    logic [AGEW-1:0]    aging [drvrs];
    logic [WAITW-1:0]   wait_cnt, wait_nxt;
    logic [pckg_sz-1:0] pkt, pkt_nxt, d_push_nxt;
    logic [drvrs-1:0]   pop_nxt, push_nxt;
    logic [15:0]        drop_nxt;
    logic               err_nxt, grant;

    logic               aged_vld, hi_vld;
    logic [IDXW-1:0]    aged_w, hi_w, lo_w, rr_sel;
    int                 rr_idx;

    // Winner: aged drivers (lowest index), else high class RR, else any pending RR.
    always_comb begin
        aged_vld = 1'b0;
        aged_w   = '0;
        hi_vld   = 1'b0;
        hi_w     = '0;
        lo_w     = '0;
        rr_idx   = 0;
        rr_sel   = '0;
        for (int j = drvrs - 1; j >= 0; j--) begin
            if (pndng[j] && aging[j] == AGE_MAX) begin
                aged_vld = 1'b1;
                aged_w   = IDXW'(j);
            end
        end
        // Descending scan so the smallest rr offset is the one left standing.
        for (int k = drvrs - 1; k >= 0; k--) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= drvrs)
                rr_idx = rr_idx - drvrs;
            rr_sel = IDXW'(rr_idx);
            if (pndng[rr_sel] && prio[rr_sel]) begin
                hi_vld = 1'b1;
                hi_w   = rr_sel;
            end
            if (pndng[rr_sel])
                lo_w = rr_sel;
        end
        win    = aged_vld ? aged_w : (hi_vld ? hi_w : lo_w);
        rr_nxt = (win == IDXW'(drvrs - 1)) ? '0 : win + 1'b1;
    end

    logic [7:0]       dst;
    logic [drvrs-1:0] src_oh, uc_oh, tgt;
    logic             dst_ok;

    assign dst    = pkt[pckg_sz-1 -: 8];
    assign src_oh = ONE << src;
    assign uc_oh  = ONE << dst;   // zero whenever dst >= drvrs

    always_comb begin
        tgt    = '0;
        dst_ok = 1'b0;
        if (dst == broadcast) begin
            tgt    = ~src_oh;
            dst_ok = 1'b1;
        end else if (uc_oh != '0 && uc_oh != src_oh) begin
            tgt    = uc_oh;
            dst_ok = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop_nxt    = '0;
        push_nxt   = '0;
        d_push_nxt = D_push;
        err_nxt    = 1'b0;
        drop_nxt   = drop_cnt;
        wait_nxt   = wait_cnt;
        pkt_nxt    = pkt;
        src_nxt    = src;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (pndng != '0) begin
                    grant     = 1'b1;
                    pop_nxt   = ONE << win;
                    src_nxt   = win;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < drvrs; i++)
                    if (src == IDXW'(i))
                        pkt_nxt = D_pop[i*pckg_sz +: pckg_sz];
                wait_nxt  = '0;
                state_nxt = ROUTE;
            end
            ROUTE: begin
                if (dst_ok && (tgt & full) == '0) begin
                    push_nxt   = tgt;
                    d_push_nxt = pkt;
                    state_nxt  = PUSH;
                end else if (!dst_ok || wait_cnt == WAIT_END) begin
                    err_nxt   = 1'b1;
                    drop_nxt  = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            PUSH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            drop_cnt <= '0;
            rr_ptr   <= '0;
            src      <= '0;
            pkt      <= '0;
            wait_cnt <= '0;
            for (int j = 0; j < drvrs; j++)
                aging[j] <= '0;
        end else begin
            state    <= state_nxt;
            pop      <= pop_nxt;
            push     <= push_nxt;
            D_push   <= d_push_nxt;
            busy     <= (state_nxt != IDLE);
            err      <= err_nxt;
            drop_cnt <= drop_nxt;
            src      <= src_nxt;
            pkt      <= pkt_nxt;
            wait_cnt <= wait_nxt;
            if (grant)
                rr_ptr <= rr_nxt;
            // A driver that drops pndng loses its accumulated age even without a grant.
            for (int j = 0; j < drvrs; j++) begin
                if (!pndng[j] || (grant && win == IDXW'(j)))
                    aging[j] <= '0;
                else if (grant && aging[j] != AGE_MAX)
                    aging[j] <= aging[j] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bs_arbiter_rr_bp.sv
// Bench for bs_arbiter_rr_bp: directed steps plus random traffic against a transaction-level model.
module tb_bs_arbiter_rr_bp;
    localparam int N = 4, W = 16, MAX_WAIT = 8, BP_TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng, prio, pop, full, push;
    logic [N*W-1:0] D_pop;
    logic [W-1:0]   D_push;
    logic           busy, err;
    logic [15:0]    drop_cnt;

    bs_arbiter_rr_bp #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF),
                       .max_wait(MAX_WAIT), .bp_timeout(BP_TO)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .prio(prio), .D_pop(D_pop),
        .pop(pop), .full(full), .push(push), .D_push(D_push), .busy(busy),
        .err(err), .drop_cnt(drop_cnt));

    always #5 clk = ~clk;

    logic [16:0] q [N][$];   // {prio, packet}
    int age [N];
    int rr;
    int drop_exp;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] dtab [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h07};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        logic [16:0] e;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                e = q[i][0];
                pndng[i] = 1'b1;
                prio[i]  = e[16];
                D_pop[i*W +: W] = e[15:0];
            end else begin
                pndng[i] = 1'b0;
                prio[i]  = 1'b0;
                D_pop[i*W +: W] = '0;
            end
        end
    endtask

    task automatic add(input int i, input logic p, input logic [15:0] d);
        q[i].push_back({p, d});
        drive();
    endtask

    function automatic int any_pending();
        int c = 0;
        for (int i = 0; i < N; i++) c += q[i].size();
        return c;
    endfunction

    function automatic logic head_prio(input int i);
        logic [16:0] e;
        e = q[i][0];
        return e[16];
    endfunction

    // Arbitration by the rules: starved drivers, then high class RR, then anyone RR.
    function automatic int model_winner();
        for (int i = 0; i < N; i++)
            if (q[i].size() > 0 && age[i] == MAX_WAIT) return i;
        for (int k = 0; k < N; k++)
            if (q[(rr + k) % N].size() > 0 && head_prio((rr + k) % N)) return (rr + k) % N;
        for (int k = 0; k < N; k++)
            if (q[(rr + k) % N].size() > 0) return (rr + k) % N;
        return 0;
    endfunction

    task automatic model_reset();
        rr = 0;
        drop_exp = 0;
        for (int i = 0; i < N; i++) age[i] = 0;
    endtask

    // One full transaction: wait for grant, follow the packet through ROUTE to push or drop.
    task automatic serve(input logic [3:0] fpat, input int hold, output logic [3:0] pop_seen);
        int w, n;
        logic [16:0] e;
        logic [15:0] pkt;
        logic [7:0] dst;
        logic [3:0] tgt, fa, w_oh;
        logic ok;
        w = model_winner();
        w_oh = 4'b1 << w;
        n = 0;
        while (pop === 4'b0 && n < 20) begin
            tick();
            n++;
        end
        pop_seen = pop;
        chk("pop_latency", n, 1);
        chk("pop_grant", pop, w_oh);
        chk("busy_grant", busy, 1);
        chk("err_low", err, 0);
        for (int j = 0; j < N; j++) begin
            if (j == w) age[j] = 0;
            else if (q[j].size() > 0) age[j] = (age[j] < MAX_WAIT) ? age[j] + 1 : MAX_WAIT;
            else age[j] = 0;
        end
        rr = (w + 1) % N;
        e = q[w][0];
        pkt = e[15:0];
        tick();
        void'(q[w].pop_front());
        drive();
        chk("pop_pulse", pop, 0);
        dst = pkt[15:8];
        ok = 1'b0;
        tgt = 4'b0;
        if (dst == 8'hFF) begin
            ok = 1'b1;
            tgt = 4'hF & ~w_oh;
        end else if (dst < 8'd4 && int'(dst) != w) begin
            ok = 1'b1;
            tgt = 4'b1 << dst;
        end
        for (int k = 1; k <= BP_TO + 2; k++) begin
            fa = (k <= hold) ? fpat : 4'b0;
            full = fa;
            tick();
            if (!ok) begin
                drop_exp++;
                chk("err_invalid", err, 1);
                chk("push_invalid", push, 0);
                chk("drop_cnt", drop_cnt, drop_exp);
                chk("busy_drop", busy, 0);
                break;
            end else if ((tgt & fa) == 4'b0) begin
                chk("push_mask", push, tgt);
                chk("push_data", D_push, pkt);
                chk("err_push", err, 0);
                tick();
                chk("push_pulse", push, 0);
                chk("push_hold", D_push, pkt);
                chk("busy_idle", busy, 0);
                break;
            end else if (k == BP_TO) begin
                drop_exp++;
                chk("err_timeout", err, 1);
                chk("push_timeout", push, 0);
                chk("drop_cnt_to", drop_cnt, drop_exp);
                break;
            end else begin
                chk("push_blocked", push, 0);
                chk("err_blocked", err, 0);
            end
        end
        full = 4'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ps, fpat;
        int n, hold, i;
        int ord [5] = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        full  = '0;
        drive();
        model_reset();
        tick();
        tick();
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dpush", D_push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b0;
        tick();

        add(1, 1'b0, 16'h02AB);
        serve(4'b0, 0, ps);
        add(3, 1'b0, 16'hFF5A);
        serve(4'b0, 0, ps);
        add(3, 1'b0, 16'hFF5A);
        serve(4'b0001, 10, ps);
        add(0, 1'b0, 16'h0700);
        serve(4'b0, 0, ps);
        add(1, 1'b0, 16'h0100);
        serve(4'b0, 0, ps);
        chk("drop_two", drop_cnt, 2);
        add(0, 1'b0, 16'h0200);
        add(3, 1'b0, 16'h0111);
        serve(4'b0100, 1000, ps);
        serve(4'b0, 0, ps);

        // High-class driver 0 stays loaded; low drivers must get through by aging.
        for (int k = 0; k < 20; k++) q[0].push_back({1'b1, 8'h01, 8'($urandom)});
        for (int d = 1; d < N; d++)
            for (int k = 0; k < 3; k++) q[d].push_back({1'b0, 8'h00, 8'($urandom)});
        drive();
        n = 0;
        while (any_pending() > 0 && n < 40) begin
            serve(4'b0, 0, ps);
            n++;
        end

        for (int it = 0; it < 40; it++) begin
            for (int a = $urandom_range(0, 2); a > 0; a--)
                add($urandom_range(0, N-1), 1'($urandom_range(0, 1)),
                    {dtab[$urandom_range(0, 5)], 8'($urandom)});
            if (any_pending() == 0)
                add($urandom_range(0, N-1), 1'b0, {dtab[$urandom_range(0, 5)], 8'($urandom)});
            fpat = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 5);
            serve(fpat, hold, ps);
        end
        n = 0;
        while (any_pending() > 0 && n < 200) begin
            serve(4'b0, 0, ps);
            n++;
        end

        // Reset while a packet is stuck in ROUTE behind full.
        add(2, 1'b0, 16'h0000);
        full = 4'b1111;
        n = 0;
        while (pop === 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_pop", pop, 4'b0100);
        tick();
        void'(q[2].pop_front());
        drive();
        tick();
        tick();
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pop", pop, 0);
        chk("mid_rst_push", push, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        model_reset();
        full = 4'b0;
        tick();
        tick();
        reset = 1'b0;

        for (int d = 0; d < N; d++)
            for (int k = 0; k < 2; k++) q[d].push_back({1'b0, 8'((d + 1) % N), 8'($urandom)});
        drive();
        for (i = 0; i < 5; i++) begin
            serve(4'b0, 0, ps);
            chk("rr_order", ps, 4'b1 << ord[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
